// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel structs, opcodes and idle defaults
package tlul_pkg;
  typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
  typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
  typedef struct packed {
    logic                        a_valid;
    tl_a_op_e                    a_opcode;
    logic [2:0]                  a_param;
    logic [top_pkg::TL_SZW-1:0]  a_size;
    logic [top_pkg::TL_AIW-1:0]  a_source;
    logic [top_pkg::TL_AW-1:0]   a_address;
    logic [top_pkg::TL_DBW-1:0]  a_mask;
    logic [top_pkg::TL_DW-1:0]   a_data;
    logic                        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic                        d_valid;
    tl_d_op_e                    d_opcode;
    logic [2:0]                  d_param;
    logic [top_pkg::TL_SZW-1:0]  d_size;
    logic [top_pkg::TL_AIW-1:0]  d_source;
    logic [top_pkg::TL_DIW-1:0]  d_sink;
    logic [top_pkg::TL_DW-1:0]   d_data;
    logic [top_pkg::TL_DUW-1:0]  d_user;
    logic                        d_error;
    logic                        a_ready;
  } tl_d2h_t;
  localparam tl_h2d_t TL_H2D_DEFAULT = '{a_opcode: PutFullData, d_ready: 1'b1, default: '0};
  localparam tl_d2h_t TL_D2H_DEFAULT = '{d_opcode: AccessAck, default: '0};
endpackage

// File: rtl/top_pkg.sv
// top_pkg: bus-wide TL-UL widths shared by every TL-UL block
package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DUW = 16;
  localparam int TL_DBW = TL_DW >> 3;
  localparam int TL_SZW = $clog2($clog2(TL_DBW) + 1);
endpackage

// File: rtl/tlul_rr_arb.sv
// tlul_rr_arb: round-robin arbiter whose grant can be held while a request is unaccepted
module tlul_rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req,
  input  logic                 lock,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] NN = N;
  logic [IW-1:0] ptr, idx_q, sel, pick;
  logic [N-1:0] rot;
  logic [IW:0] sum;
  logic locked_q, any;
  always_comb begin
    rot = N'({req, req} >> ptr);
    sel = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) sel = IW'(k);
    sum = {1'b0, sel} + {1'b0, ptr};
    pick = sum >= NN ? IW'(sum - NN) : sum[IW-1:0];
    gnt_idx = locked_q ? idx_q : pick;
    any = locked_q | (|req);
    gnt = any ? N'(1) << gnt_idx : '0;
  end
  // lock low with a live grant means the device took the request this cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
      idx_q <= '0;
      locked_q <= 1'b0;
    end else begin
      locked_q <= lock;
      idx_q <= gnt_idx;
      if (any && !lock) ptr <= gnt_idx == IW'(N - 1) ? '0 : gnt_idx + IW'(1);
    end
  end
endmodule

// File: rtl/tlul_socket_m1.sv
// tlul_socket_m1: N-host to 1-device TL-UL socket with per-host outstanding limits
module tlul_socket_m1
  import tlul_pkg::*;
#(
  parameter int NumHosts       = 4,
  parameter int MaxOutstanding = 4,
  parameter int HostIdxW       = $clog2(NumHosts)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  tl_h2d_t     tl_h_i [NumHosts],
  output tl_d2h_t     tl_h_o [NumHosts],
  output tl_h2d_t     tl_d_o,
  input  tl_d2h_t     tl_d_i,
  output logic [3:0]  outst_o [NumHosts],
  output logic        src_err_o
);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int AIW = top_pkg::TL_AIW;
  logic [CntW-1:0] outst [NumHosts];
  logic [NumHosts-1:0] elig, gnt, a_hs, d_hs, d_hit, zero;
  logic [$clog2(NumHosts)-1:0] gidx;
  logic lock;
  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      elig[i] = tl_h_i[i].a_valid && outst[i] != CntW'(MaxOutstanding);
      zero[i] = outst[i] == '0;
      outst_o[i] = 4'(outst[i]);
    end
  end
  tlul_rr_arb #(.N(NumHosts)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (elig),
    .lock    (lock),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );
  // host tag occupies the low source bits so responses can be routed back
  always_comb begin
    tl_d_o = TL_H2D_DEFAULT;
    if (|gnt) begin
      tl_d_o = tl_h_i[gidx];
      tl_d_o.a_source = {tl_h_i[gidx].a_source[AIW-HostIdxW-1:0], HostIdxW'(gidx)};
    end
    lock = tl_d_o.a_valid & ~tl_d_i.a_ready;
    d_hit = '0;
    tl_d_o.d_ready = 1'b1;
    for (int i = 0; i < NumHosts; i++) begin
      d_hit[i] = tl_d_i.d_source[HostIdxW-1:0] == HostIdxW'(i);
      if (d_hit[i]) tl_d_o.d_ready = tl_h_i[i].d_ready;
      tl_h_o[i] = tl_d_i;
      tl_h_o[i].d_source = tl_d_i.d_source >> HostIdxW;
      tl_h_o[i].d_valid = tl_d_i.d_valid & d_hit[i];
      tl_h_o[i].a_ready = gnt[i] & tl_d_i.a_ready;
      a_hs[i] = tl_h_o[i].a_ready & tl_h_i[i].a_valid;
      d_hs[i] = tl_h_o[i].d_valid & tl_h_i[i].d_ready;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumHosts; i++) outst[i] <= '0;
      src_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < NumHosts; i++) begin
        if (a_hs[i] && !d_hs[i]) outst[i] <= outst[i] + CntW'(1);
        else if (d_hs[i] && !a_hs[i] && !zero[i]) outst[i] <= outst[i] - CntW'(1);
      end
      if ((tl_d_i.d_valid && !(|d_hit)) || |(d_hs & zero)) src_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tlul_socket_m1.sv
// tb_tlul_socket_m1: directed scoreboard bench for the TL-UL 1-device socket
module tb_tlul_socket_m1;
  import tlul_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tl_h2d_t h [4];
  tl_d2h_t hr [4];
  tl_h2d_t d_o;
  tl_d2h_t d_i;
  logic [3:0] outst [4];
  logic err;
  tl_h2d_t h3 [3];
  tl_d2h_t hr3 [3];
  tl_h2d_t d3_o;
  tl_d2h_t d3_i;
  logic [3:0] outst3 [3];
  logic err3;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] e;

  tlul_socket_m1 #(.NumHosts(4), .MaxOutstanding(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .tl_h_i(h), .tl_h_o(hr), .tl_d_o(d_o), .tl_d_i(d_i),
    .outst_o(outst), .src_err_o(err)
  );
  tlul_socket_m1 #(.NumHosts(3), .MaxOutstanding(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .tl_h_i(h3), .tl_h_o(hr3), .tl_d_o(d3_o), .tl_d_i(d3_i),
    .outst_o(outst3), .src_err_o(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every accepted A request must match the oldest queued expectation
  task automatic go();
    if (d_o.a_valid && d_i.a_ready) begin
      chk("hs_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("a_source", {24'h0, d_o.a_source}, {24'h0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) h[i] = TL_H2D_DEFAULT;
    for (int i = 0; i < 3; i++) begin
      h3[i] = TL_H2D_DEFAULT;
      h3[i].d_ready = 1'b0;
    end
    d_i = TL_D2H_DEFAULT;
    d_i.a_ready = 1'b1;
    d3_i = TL_D2H_DEFAULT;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_outst", 32'(outst[i]), 0);
      chk("rst_a_ready", 32'(hr[i].a_ready), 0);
      chk("rst_d_valid", 32'(hr[i].d_valid), 0);
    end
    chk("rst_err", 32'(err), 0);
    chk("rst_a_valid", 32'(d_o.a_valid), 0);
    rst = 1'b0;
    // fairness: four streaming hosts, limit 2 each, no responses
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) exp_q.push_back({6'(i + 1), 2'(i)});
    for (int i = 0; i < 4; i++) begin
      h[i].a_valid = 1'b1;
      h[i].a_opcode = Get;
      h[i].a_source = 8'(i + 1);
      h[i].a_address = 32'h1000 + 32'(i * 4);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      #1;
      if (d_o.a_valid) chk("fair_a_ready", 32'(hr[d_o.a_source[1:0]].a_ready), 1);
      go();
    end
    chk("fair_done", 32'(exp_q.size()), 0);
    #1;
    chk("limit_a_valid", 32'(d_o.a_valid), 0);
    for (int i = 0; i < 4; i++) chk("limit_outst", 32'(outst[i]), 2);
    chk("limit_a_ready", 32'(hr[1].a_ready), 0);
    // one response to host 1 reopens it
    for (int i = 0; i < 4; i++) h[i].a_valid = (i == 1);
    h[1].d_ready = 1'b0;
    d_i.d_valid = 1'b1;
    d_i.d_opcode = AccessAckData;
    d_i.d_source = 8'h09;
    d_i.d_data = 32'hA5A5_0001;
    d_i.d_user = 16'h1234;
    #1;
    chk("d_ready_follow0", 32'(d_o.d_ready), 0);
    h[1].d_ready = 1'b1;
    #1;
    chk("d_ready_follow1", 32'(d_o.d_ready), 1);
    chk("d_valid_h1", 32'(hr[1].d_valid), 1);
    chk("d_source_h1", 32'(hr[1].d_source), 2);
    chk("d_data_h1", hr[1].d_data, 32'hA5A5_0001);
    chk("d_user_h1", 32'(hr[1].d_user), 32'h1234);
    chk("d_valid_h0", 32'(hr[0].d_valid), 0);
    chk("d_valid_h2", 32'(hr[2].d_valid), 0);
    go();
    d_i.d_valid = 1'b0;
    exp_q.push_back(8'h09);
    #1;
    chk("resp_outst1", 32'(outst[1]), 1);
    chk("reopen_a_ready", 32'(hr[1].a_ready), 1);
    go();
    h[1].a_valid = 1'b0;
    #1;
    chk("third_hs_outst1", 32'(outst[1]), 2);
    // simultaneous A and D handshake on host 3
    d_i.d_valid = 1'b1;
    d_i.d_source = 8'h13;
    #1;
    go();
    chk("pre_sim_outst3", 32'(outst[3]), 1);
    h[3].a_valid = 1'b1;
    exp_q.push_back(8'h13);
    #1;
    chk("sim_a_ready", 32'(hr[3].a_ready), 1);
    chk("sim_d_valid", 32'(hr[3].d_valid), 1);
    go();
    d_i.d_valid = 1'b0;
    h[3].a_valid = 1'b0;
    #1;
    chk("sim_outst3", 32'(outst[3]), 1);
    // free hosts 0 and 2, then lock host 2 while host 0 waits
    d_i.d_valid = 1'b1;
    d_i.d_source = 8'h04;
    #1;
    go();
    d_i.d_source = 8'h0E;
    #1;
    go();
    d_i.d_valid = 1'b0;
    d_i.a_ready = 1'b0;
    h[2].a_valid = 1'b1;
    h[2].a_source = 8'd5;
    h[2].a_address = 32'h2000;
    exp_q.push_back(8'h16);
    exp_q.push_back(8'h04);
    #1;
    chk("free_outst0", 32'(outst[0]), 1);
    chk("free_outst2", 32'(outst[2]), 1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) h[0].a_valid = 1'b1;
      #1;
      chk("lock_source", {24'h0, d_o.a_source}, 32'h16);
      chk("lock_addr", d_o.a_address, 32'h2000);
      chk("lock_h0_rdy", 32'(hr[0].a_ready), 0);
      go();
    end
    d_i.a_ready = 1'b1;
    #1;
    chk("unlock_h2_rdy", 32'(hr[2].a_ready), 1);
    go();
    h[2].a_valid = 1'b0;
    #1;
    chk("next_h0_rdy", 32'(hr[0].a_ready), 1);
    go();
    h[0].a_valid = 1'b0;
    #1;
    chk("lock_q_empty", 32'(exp_q.size()), 0);
    chk("lock_outst0", 32'(outst[0]), 2);
    chk("lock_outst2", 32'(outst[2]), 2);
    // reset clears bookkeeping; a late response then underflows
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst2_outst2", 32'(outst[2]), 0);
    chk("rst2_err", 32'(err), 0);
    d_i.d_valid = 1'b1;
    d_i.d_source = 8'h0E;
    #1;
    go();
    d_i.d_valid = 1'b0;
    #1;
    chk("uflow_outst2", 32'(outst[2]), 0);
    chk("uflow_err", 32'(err), 1);
    // out-of-range tag on the three-host socket
    chk("bad_err_pre", 32'(err3), 0);
    d3_i.d_valid = 1'b1;
    d3_i.d_source = 8'h07;
    #1;
    chk("bad_d_ready", 32'(d3_o.d_ready), 1);
    for (int i = 0; i < 3; i++) chk("bad_d_valid", 32'(hr3[i].d_valid), 0);
    go();
    d3_i.d_valid = 1'b0;
    repeat (3) go();
    chk("bad_err_sticky", 32'(err3), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("bad_err_rst", 32'(err3), 0);
    chk("err_rst", 32'(err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
